// File: rtl/mux_pkg.sv
// ============================================================================
// Module      : mux_pkg
// Description : Shared state encoding, widths and helpers for the mux sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

    localparam int SEL_W     = 2;
    localparam int NUM_CH    = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [SEL_W-1:0] s);
        return 4'b0001 << s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_4to1_case.sv
// ============================================================================
// Module      : mux_4to1_case
// Description : Combinational 4:1 data multiplexer driven by a 2-bit select.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux_4to1_case #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        case (sel)
            2'd0:    out = a;
            2'd1:    out = b;
            2'd2:    out = c;
            default: out = d;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/rr_pick4.sv
// ============================================================================
// Module      : rr_pick4
// Description : Combinational 4-way round-robin pick starting after ptr.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module rr_pick4
    import mux_pkg::*;
(
    input  logic [3:0]       req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] w_idx;

    // Walk from lowest to highest priority so the nearest requester after ptr overwrites last.
    always_comb begin
        pick  = ptr;
        w_idx = ptr;
        for (int i = 4; i >= 1; i--) begin
            w_idx = ptr + SEL_W'(i);
            if (req[w_idx]) begin
                pick = w_idx;
            end
        end
    end

    assign any = |req;

endmodule

`default_nettype wire

// File: rtl/mux_rr_sequencer.sv
// ============================================================================
// Module      : mux_rr_sequencer
// Description : Round-robin select/capture stage around a 4:1 mux, valid/ready out.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mux_rr_sequencer
    import mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_CH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    output logic [3:0]       gnt,
    output logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    if (NUM_CH != 4) begin : g_cfg_check
        $error("mux_rr_sequencer: NUM_CH must be 4");
    end

    state_t           r_state;
    state_t           w_next_state;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [3:0]       r_gnt;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SEL_W-1:0] w_pick;
    logic             w_any;
    logic             w_load_sel;
    logic             w_capture;
    logic             w_release;

    rr_pick4 u_pick (
        .req  (req),
        .ptr  (r_ptr),
        .pick (w_pick),
        .any  (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_next_state = ST_SETTLE;
            ST_SETTLE: w_next_state = ST_HOLD;
            ST_HOLD:   if (out_ready) w_next_state = w_any ? ST_SETTLE : ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load_sel = 1'b0;
        w_capture  = 1'b0;
        w_release  = 1'b0;
        case (r_state)
            ST_IDLE:   w_load_sel = w_any;
            ST_SETTLE: w_capture  = 1'b1;
            ST_HOLD: begin
                w_load_sel = out_ready & w_any;
                w_release  = out_ready;
            end
            default: ;
        endcase
    end

    // Capture uses the applied select, not a fresh pick, so a request dropped in SETTLE still completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel   <= '0;
            r_ptr   <= SEL_W'(3);
            r_gnt   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_load_sel) r_sel <= w_pick;
            if (w_capture) begin
                r_data  <= mux_out;
                r_valid <= 1'b1;
                r_gnt   <= onehot4(r_sel);
                r_ptr   <= r_sel;
            end else begin
                r_gnt   <= '0;
            end
            if (w_release) r_valid <= 1'b0;
        end
    end

    assign sel       = r_sel;
    assign gnt       = r_gnt;
    assign out_data  = r_data;
    assign out_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_sequencer.sv
// ============================================================================
// Module      : tb_mux_rr_sequencer
// Description : Scoreboard bench for mux_rr_sequencer driving mux_4to1_case.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mux_rr_sequencer;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req = 4'b0;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] a = 4'h0, b = 4'h5, c = 4'hA, d = 4'hF;

    int checks = 0;
    int errors = 0;
    int n_gnt  = 0;
    int cyc    = 0;
    logic [7:0] sb[$];
    int gnt_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mux_4to1_case #(.WIDTH(WIDTH)) u_mux (
        .a(a), .b(b), .c(c), .d(d), .sel(sel), .out(mux_out)
    );

    mux_rr_sequencer #(.WIDTH(WIDTH), .NUM_CH(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .sel(sel),
        .mux_out(mux_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every grant pulse must match the next expected {data, gnt}.
    always @(negedge clk) begin
        if (rst_n && gnt != 4'b0) begin
            chk("gnt_implies_valid", {31'b0, out_valid}, 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_gnt", {24'b0, out_data, gnt}, 32'hFFFF_FFFF);
            end else begin
                chk("word_gnt", {24'b0, out_data, gnt}, {24'b0, sb.pop_front()});
            end
            n_gnt++;
            gnt_cyc.push_back(cyc);
        end
    end

    task automatic wait_gnt(input int target, input string name);
        for (int k = 0; k < 60 && n_gnt < target; k++) begin
            @(negedge clk);
            #1;
        end
        chk(name, {31'b0, n_gnt >= target}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // 1: reset release, idle
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_data", {28'b0, out_data}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_sel", {30'b0, sel}, 32'd0);
            chk("idle_valid", {31'b0, out_valid}, 32'd0);
            chk("idle_gnt", {28'b0, gnt}, 32'd0);
        end

        // 2: single request on channel 2
        req = 4'b0100;
        out_ready = 1'b1;
        sb.push_back({4'hA, 4'b0100});
        @(negedge clk);
        chk("t2_sel_latency", {30'b0, sel}, 32'd2);
        chk("t2_valid_not_yet", {31'b0, out_valid}, 32'd0);
        wait_gnt(1, "t2_gnt_timeout");
        req = 4'b0;
        @(negedge clk);
        chk("t2_gnt_one_cycle", {28'b0, gnt}, 32'd0);
        chk("t2_released", {31'b0, out_valid}, 32'd0);

        // 3: all requesting from a fresh pointer
        do_reset();
        gnt_cyc.delete();
        sb.push_back({4'h0, 4'b0001});
        sb.push_back({4'h5, 4'b0010});
        sb.push_back({4'hA, 4'b0100});
        sb.push_back({4'hF, 4'b1000});
        sb.push_back({4'h0, 4'b0001});
        @(negedge clk);
        req = 4'b1111;
        wait_gnt(n_gnt + 5, "t3_gnt_timeout");
        req = 4'b0;
        for (int i = 0; i < 4; i++) begin
            if (gnt_cyc.size() > i + 1)
                chk("t3_throughput", gnt_cyc[i+1] - gnt_cyc[i], 32'd2);
        end
        repeat (2) @(negedge clk);

        // 4: backpressure on channel 1
        out_ready = 1'b0;
        req = 4'b0010;
        sb.push_back({4'h5, 4'b0010});
        wait_gnt(n_gnt + 1, "t4_gnt_timeout");
        req = 4'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("t4_hold_data", {28'b0, out_data}, 32'h5);
        end
        chk("t4_hold_sel", {30'b0, sel}, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_accepted", {31'b0, out_valid}, 32'd0);

        // 5: request dropped during SETTLE
        req = 4'b1000;
        sb.push_back({4'hF, 4'b1000});
        @(posedge clk);
        #1 req = 4'b0;
        wait_gnt(n_gnt + 1, "t5_gnt_timeout");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_idle_valid", {31'b0, out_valid}, 32'd0);
            chk("t5_idle_sel", {30'b0, sel}, 32'd3);
        end

        // 6: asynchronous reset while holding a word
        out_ready = 1'b0;
        req = 4'b0100;
        sb.push_back({4'hA, 4'b0100});
        wait_gnt(n_gnt + 1, "t6_gnt_timeout");
        rst_n = 1'b0;
        req = 4'b0;
        #1;
        chk("t6_async_valid", {31'b0, out_valid}, 32'd0);
        chk("t6_async_gnt", {28'b0, gnt}, 32'd0);
        chk("t6_async_sel", {30'b0, sel}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1001;
        out_ready = 1'b1;
        sb.push_back({4'h0, 4'b0001});
        sb.push_back({4'hF, 4'b1000});
        wait_gnt(n_gnt + 2, "t6_gnt_timeout2");
        req = 4'b0;
        repeat (4) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
